// File: rtl/dds_multichannel_core.sv
//-----------------------------------------------------------------------------
// dds_multichannel_core
//
// Time-multiplexed direct digital synthesis core. One shared three-stage
// pipeline (issue -> waveform -> scale) serves CHANNELS channels. Each
// accepted sample_tick starts a frame that emits one sample per channel in
// channel order.
//
// Ports:
//   clk          core clock
//   rst          synchronous reset, active low
//   sample_tick  one-cycle frame request (ignored while busy, flags overrun)
//   phase_sync   request to restart all accumulators at the next frame
//   cfg_we       configuration write strobe into the shadow registers
//   cfg_ch       target channel (out-of-range writes are dropped)
//   cfg_addr     0 = tune, 1 = phase offset, 2 = amplitude, 3 = shape
//   cfg_data     write data, LSB-aligned
//   overrun_clr  clears the sticky overrun flag
//   sample_out   scaled offset-binary sample
//   sample_ch    channel index of sample_out
//   sample_valid sample_out / sample_ch qualifier
//   frame_done   marks the last channel's sample of a frame
//   busy         frame in progress
//   overrun      sticky: a tick arrived while busy
//
// Output handshake: sample_valid is a pure qualifier with no ready/backpressure;
// the downstream stage must take sample_out/sample_ch in every cycle where
// sample_valid is high. Valids of one frame are contiguous.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module dds_multichannel_core #(
  parameter int CHANNELS = 2,
  parameter int PHASE_W  = 14,
  parameter int TUNE_W   = 13,
  parameter int AMP_W    = 11,
  parameter int OUT_W    = 12,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_tick,
  input  logic               phase_sync,
  input  logic               cfg_we,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [1:0]         cfg_addr,
  input  logic [PHASE_W-1:0] cfg_data,
  input  logic               overrun_clr,
  output logic [OUT_W-1:0]   sample_out,
  output logic [CH_W-1:0]    sample_ch,
  output logic               sample_valid,
  output logic               frame_done,
  output logic               busy,
  output logic               overrun
);

  localparam logic [OUT_W-1:0] MID       = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [1:0]       SHAPE_OFF = 2'd3;
  localparam int               PW        = OUT_W + AMP_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t            state, state_nxt;
  logic [CH_W-1:0]   issue_ch;
  logic              tick_acc, issue_en, issue_last;
  logic              sync_pend, frame_sync;
  logic              cfg_ok;

  logic [TUNE_W-1:0]  tune_sh [CHANNELS];
  logic [PHASE_W-1:0] off_sh  [CHANNELS];
  logic [AMP_W-1:0]   amp_sh  [CHANNELS];
  logic [1:0]         shape_sh[CHANNELS];
  logic [TUNE_W-1:0]  tune_act [CHANNELS];
  logic [PHASE_W-1:0] off_act  [CHANNELS];
  logic [AMP_W-1:0]   amp_act  [CHANNELS];
  logic [1:0]         shape_act[CHANNELS];
  logic [PHASE_W-1:0] acc      [CHANNELS];

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (tick_acc) state_nxt = S_RUN;
      S_RUN:   if (issue_last) state_nxt = S_DRAIN;
      // Leave once the last channel's sample is on the output.
      S_DRAIN: if (sample_valid && frame_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != S_IDLE);
    tick_acc   = sample_tick && (state == S_IDLE);
    issue_en   = (state == S_RUN);
    issue_last = issue_en && (issue_ch == CH_W'(CHANNELS - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst)          issue_ch <= '0;
    else if (tick_acc) issue_ch <= '0;
    else if (issue_en) issue_ch <= issue_ch + 1'b1;
  end

  // ---------------- Configuration ----------------
  assign cfg_ok = cfg_we && (int'(cfg_ch) < CHANNELS);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        tune_sh[i]  <= '0;
        off_sh[i]   <= '0;
        amp_sh[i]   <= '0;
        shape_sh[i] <= SHAPE_OFF;
      end
    end else if (cfg_ok) begin
      case (cfg_addr)
        2'd0:    tune_sh[cfg_ch]  <= cfg_data[TUNE_W-1:0];
        2'd1:    off_sh[cfg_ch]   <= cfg_data;
        2'd2:    amp_sh[cfg_ch]   <= cfg_data[AMP_W-1:0];
        default: shape_sh[cfg_ch] <= cfg_data[1:0];
      endcase
    end
  end

  // Active set is loaded from the shadow as it stood before this edge, so a
  // write landing in the tick cycle only affects the following frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        tune_act[i]  <= '0;
        off_act[i]   <= '0;
        amp_act[i]   <= '0;
        shape_act[i] <= SHAPE_OFF;
      end
    end else if (tick_acc) begin
      for (int i = 0; i < CHANNELS; i++) begin
        tune_act[i]  <= tune_sh[i];
        off_act[i]   <= off_sh[i];
        amp_act[i]   <= amp_sh[i];
        shape_act[i] <= shape_sh[i];
      end
    end
  end

  // A sync request raised in the tick cycle itself is taken by that frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_pend  <= 1'b0;
      frame_sync <= 1'b0;
    end else if (tick_acc) begin
      sync_pend  <= 1'b0;
      frame_sync <= sync_pend | phase_sync;
    end else if (phase_sync) begin
      sync_pend  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)                               overrun <= 1'b0;
    else if (sample_tick && busy)           overrun <= 1'b1;
    else if (overrun_clr)                   overrun <= 1'b0;
  end

  // ---------------- Stage 1: phase issue ----------------
  logic [PHASE_W-1:0] p1, acc_nxt, cur_acc, cur_off, cur_tune;
  logic [1:0]         cur_shape;

  always_comb begin
    cur_acc   = acc[issue_ch];
    cur_off   = off_act[issue_ch];
    cur_tune  = PHASE_W'(tune_act[issue_ch]);
    cur_shape = shape_act[issue_ch];
    p1        = cur_acc + cur_off;
    acc_nxt   = cur_acc;
    if (frame_sync) begin
      p1      = cur_off;
      acc_nxt = (cur_shape == SHAPE_OFF) ? '0 : cur_tune;
    end else if (cur_shape != SHAPE_OFF) begin
      acc_nxt = cur_acc + cur_tune;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
    end else if (issue_en) begin
      acc[issue_ch] <= acc_nxt;
    end
  end

  logic               s1_valid, s1_last;
  logic [CH_W-1:0]    s1_ch;
  logic [PHASE_W-1:0] s1_p;
  logic [1:0]         s1_shape;
  logic [AMP_W-1:0]   s1_amp;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_ch    <= '0;
      s1_p     <= '0;
      s1_shape <= SHAPE_OFF;
      s1_amp   <= '0;
    end else begin
      s1_valid <= issue_en;
      s1_last  <= issue_last;
      s1_ch    <= issue_ch;
      s1_p     <= p1;
      s1_shape <= cur_shape;
      s1_amp   <= amp_act[issue_ch];
    end
  end

  // ---------------- Stage 2: waveform ----------------
  logic [OUT_W-1:0] raw;

  always_comb begin
    raw = MID;
    case (s1_shape)
      2'd0: raw = s1_p[PHASE_W-1 -: OUT_W];
      2'd1: raw = s1_p[PHASE_W-1] ? ~s1_p[PHASE_W-2 -: OUT_W] : s1_p[PHASE_W-2 -: OUT_W];
      2'd2: raw = {OUT_W{~s1_p[PHASE_W-1]}};
      default: raw = MID;
    endcase
  end

  logic             s2_valid, s2_last;
  logic [CH_W-1:0]  s2_ch;
  logic [OUT_W-1:0] s2_raw;
  logic [AMP_W-1:0] s2_amp;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_ch    <= '0;
      s2_raw   <= MID;
      s2_amp   <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_ch    <= s1_ch;
      s2_raw   <= raw;
      s2_amp   <= s1_amp;
    end
  end

  // ---------------- Stage 3: amplitude scale ----------------
  // Flipping the MSB converts offset-binary to two's complement (raw - MID)
  // and back. |s*amp/2^AMP_W| < |s|, so the result always fits OUT_W bits.
  logic signed [PW-1:0] s_ext, a_ext, prod, shifted;
  logic [OUT_W-1:0]     scaled;
  logic                 unused_bits;

  always_comb begin
    s_ext   = PW'($signed({~s2_raw[OUT_W-1], s2_raw[OUT_W-2:0]}));
    a_ext   = $signed(PW'({1'b0, s2_amp}));
    prod    = s_ext * a_ext;
    shifted = prod >>> AMP_W;
    scaled  = {~shifted[OUT_W-1], shifted[OUT_W-2:0]};
  end

  assign unused_bits = ^shifted[PW-1:OUT_W];

  always_ff @(posedge clk) begin
    if (!rst) begin
      sample_out   <= MID;
      sample_ch    <= '0;
      sample_valid <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      sample_valid <= s2_valid;
      frame_done   <= s2_valid && s2_last;
      if (s2_valid) begin
        sample_out <= scaled;
        sample_ch  <= s2_ch;
      end
    end
  end

endmodule

// File: tb/tb_dds_multichannel_core.sv
`timescale 1ns/1ps

module tb_dds_multichannel_core;

  localparam int CHANNELS = 2;
  localparam int PHASE_W  = 14;
  localparam int TUNE_W   = 13;
  localparam int AMP_W    = 11;
  localparam int OUT_W    = 12;
  localparam int CH_W     = 1;
  localparam int MID      = 2 ** (OUT_W - 1);
  localparam int PMOD     = 2 ** PHASE_W;
  localparam int HALF     = 2 ** (PHASE_W - 1);

  // ---------------- clock / reset / DUT ----------------
  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               sample_tick = 1'b0;
  logic               phase_sync = 1'b0;
  logic               cfg_we = 1'b0;
  logic [CH_W-1:0]    cfg_ch = '0;
  logic [1:0]         cfg_addr = '0;
  logic [PHASE_W-1:0] cfg_data = '0;
  logic               overrun_clr = 1'b0;
  logic [OUT_W-1:0]   sample_out;
  logic [CH_W-1:0]    sample_ch;
  logic               sample_valid, frame_done, busy, overrun;

  always #5 clk = ~clk;

  dds_multichannel_core #(
    .CHANNELS(CHANNELS), .PHASE_W(PHASE_W), .TUNE_W(TUNE_W),
    .AMP_W(AMP_W), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .phase_sync(phase_sync),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .overrun_clr(overrun_clr), .sample_out(sample_out), .sample_ch(sample_ch),
    .sample_valid(sample_valid), .frame_done(frame_done), .busy(busy),
    .overrun(overrun)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [OUT_W-1:0] exp_q[$];
  logic [OUT_W-1:0] got_s[CHANNELS];

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Advance one cycle; outputs are sampled and inputs driven 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  int m_sh_tune[CHANNELS], m_sh_off[CHANNELS], m_sh_amp[CHANNELS], m_sh_shape[CHANNELS];
  int m_tune[CHANNELS], m_off[CHANNELS], m_amp[CHANNELS], m_shape[CHANNELS];
  int m_acc[CHANNELS];
  bit m_pend;

  task automatic model_reset();
    for (int i = 0; i < CHANNELS; i++) begin
      m_sh_tune[i] = 0; m_sh_off[i] = 0; m_sh_amp[i] = 0; m_sh_shape[i] = 3;
      m_tune[i] = 0; m_off[i] = 0; m_amp[i] = 0; m_shape[i] = 3;
      m_acc[i] = 0;
    end
    m_pend = 1'b0;
  endtask

  task automatic model_write(input int ch, input int addr, input int data);
    if (ch < CHANNELS) begin
      case (addr)
        0: m_sh_tune[ch]  = data % (2 ** TUNE_W);
        1: m_sh_off[ch]   = data % PMOD;
        2: m_sh_amp[ch]   = data % (2 ** AMP_W);
        default: m_sh_shape[ch] = data % 4;
      endcase
    end
  endtask

  function automatic int wave(input int shape, input int p);
    int v;
    case (shape)
      0: return p / (2 ** (PHASE_W - OUT_W));
      1: begin
        v = (p % HALF) / (2 ** (PHASE_W - 1 - OUT_W));
        return (p >= HALF) ? (2 ** OUT_W - 1 - v) : v;
      end
      2: return (p >= HALF) ? 0 : 2 ** OUT_W - 1;
      default: return MID;
    endcase
  endfunction

  function automatic int scale(input int raw, input int amp);
    int x, q;
    x = (raw - MID) * amp;
    q = (x >= 0) ? x / (2 ** AMP_W) : -((-x + 2 ** AMP_W - 1) / (2 ** AMP_W));
    return MID + q;
  endfunction

  // Model of one accepted tick; ps_now / write args describe the tick cycle.
  task automatic model_frame(input bit ps_now, input bit we, input int ch,
                             input int addr, input int data);
    bit fs;
    int p;
    for (int i = 0; i < CHANNELS; i++) begin
      m_tune[i] = m_sh_tune[i]; m_off[i] = m_sh_off[i];
      m_amp[i]  = m_sh_amp[i];  m_shape[i] = m_sh_shape[i];
    end
    fs = m_pend | ps_now;
    m_pend = 1'b0;
    if (we) model_write(ch, addr, data);
    for (int k = 0; k < CHANNELS; k++) begin
      if (fs) begin
        p = m_off[k];
        m_acc[k] = (m_shape[k] == 3) ? 0 : m_tune[k];
      end else begin
        p = (m_acc[k] + m_off[k]) % PMOD;
        if (m_shape[k] != 3) m_acc[k] = (m_acc[k] + m_tune[k]) % PMOD;
      end
      exp_q.push_back(OUT_W'(scale(wave(m_shape[k], p), m_amp[k])));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    sample_tick = 1'b0; phase_sync = 1'b0; cfg_we = 1'b0;
    cfg_ch = '0; cfg_addr = '0; cfg_data = '0; overrun_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    step();
    step();
    rst = 1'b1;
    model_reset();
    check("rst_sample_out", int'(sample_out), MID);
    check("rst_sample_ch", int'(sample_ch), 0);
    check("rst_valid", int'(sample_valid), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
  endtask

  task automatic write_cfg(input int ch, input int addr, input int data);
    cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_addr = 2'(addr); cfg_data = PHASE_W'(data);
    step();
    cfg_we = 1'b0;
  endtask

  // Raise the tick in the current cycle T (other inputs already set by the
  // caller), then check busy/valid/channel/frame_done timing through T+C+4.
  task automatic run_frame();
    bit exp_v;
    sample_tick = 1'b1;
    step();
    clear_inputs();
    for (int j = 1; j <= CHANNELS + 4; j++) begin
      exp_v = (j >= 4) && (j <= CHANNELS + 3);
      check("busy", int'(busy), int'(j <= CHANNELS + 3));
      check("sample_valid", int'(sample_valid), int'(exp_v));
      check("frame_done", int'(frame_done), int'(j == CHANNELS + 3));
      if (exp_v) begin
        check("sample_ch", int'(sample_ch), j - 4);
        got_s[j-4] = sample_out;
      end
      if (j < CHANNELS + 4) step();
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int    ch;
    bit    rst_first;
    bit    sync;
    int    tune;
    int    offset;
    int    amp;
    int    shape;
    int    exp_out;
    string name;
  } vec_t;

  vec_t vecs[17];

  initial begin
    int vcount;
    int n_idle;
    bit we, ps;
    int wch, waddr, wdata;

    vecs[0]  = '{0, 1, 0, 0,    0,      0,    3, 2048, "no_config"};
    vecs[1]  = '{1, 1, 1, 4096, 0,      1024, 2, 3071, "square_f0"};
    vecs[2]  = '{1, 0, 0, 4096, 0,      1024, 2, 3071, "square_f1"};
    vecs[3]  = '{1, 0, 0, 4096, 0,      1024, 2, 1024, "square_f2"};
    vecs[4]  = '{1, 0, 0, 4096, 0,      1024, 2, 1024, "square_f3"};
    vecs[5]  = '{1, 0, 0, 4096, 0,      1024, 2, 3071, "square_f4"};
    vecs[6]  = '{0, 1, 1, 1024, 0,      2047, 0, 1,    "saw_f0"};
    vecs[7]  = '{0, 0, 0, 1024, 0,      2047, 0, 256,  "saw_f1"};
    vecs[8]  = '{0, 0, 0, 1024, 0,      2047, 0, 512,  "saw_f2"};
    vecs[9]  = '{0, 1, 1, 8191, 16128,  2047, 0, 4031, "wrap_f0"};
    vecs[10] = '{0, 0, 0, 8191, 16128,  2047, 0, 1983, "wrap_f1"};
    vecs[11] = '{0, 0, 0, 8191, 16128,  2047, 0, 4030, "wrap_f2"};
    vecs[12] = '{0, 0, 0, 8191, 16128,  2047, 0, 1983, "wrap_f3"};
    vecs[13] = '{0, 1, 1, 4096, 0,      2047, 1, 1,    "tri_f0"};
    vecs[14] = '{0, 0, 0, 4096, 0,      2047, 1, 2048, "tri_f1"};
    vecs[15] = '{0, 0, 0, 4096, 0,      2047, 1, 4094, "tri_f2"};
    vecs[16] = '{0, 0, 0, 4096, 0,      2047, 1, 2047, "tri_f3"};

    clear_inputs();
    model_reset();

    for (int v = 0; v < 17; v++) begin
      if (vecs[v].rst_first) do_reset();
      write_cfg(vecs[v].ch, 0, vecs[v].tune);
      write_cfg(vecs[v].ch, 1, vecs[v].offset);
      write_cfg(vecs[v].ch, 2, vecs[v].amp);
      write_cfg(vecs[v].ch, 3, vecs[v].shape);
      if (vecs[v].sync) begin
        phase_sync = 1'b1;
        step();
        phase_sync = 1'b0;
      end
      run_frame();
      for (int k = 0; k < CHANNELS; k++)
        check(vecs[v].name, int'(got_s[k]), (k == vecs[v].ch) ? vecs[v].exp_out : MID);
    end

    // ---- overrun: second tick two cycles into the frame ----
    do_reset();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check("overrun_set", int'(overrun), 1);
    vcount = 0;
    for (int j = 3; j <= 12; j++) begin
      if (sample_valid) vcount++;
      if (j == CHANNELS + 4) check("overrun_busy_end", int'(busy), 0);
      step();
    end
    check("overrun_valid_count", vcount, CHANNELS);
    check("overrun_sticky", int'(overrun), 1);
    // clear and tick-while-busy in the same cycle: set wins
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b1;
    overrun_clr = 1'b1;
    step();
    clear_inputs();
    check("overrun_clr_vs_set", int'(overrun), 1);
    for (int j = 0; j < 8; j++) step();
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    check("overrun_cleared", int'(overrun), 0);
    run_frame();
    check("overrun_idle_tick", int'(overrun), 0);

    // ---- amplitude write in the tick cycle, then reset mid-frame ----
    do_reset();
    write_cfg(0, 0, 0);
    write_cfg(0, 1, 0);
    write_cfg(0, 3, 0);
    write_cfg(0, 2, 100);
    cfg_we = 1'b1; cfg_ch = '0; cfg_addr = 2'd2; cfg_data = PHASE_W'(500);
    run_frame();
    check("amp_old", int'(got_s[0]), MID - 100);
    check("amp_old_ch1", int'(got_s[1]), MID);
    run_frame();
    check("amp_new", int'(got_s[0]), MID - 500);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    step();
    step();
    check("midrst_valid_t4", int'(sample_valid), 1);
    check("midrst_sample_t4", int'(sample_out), MID - 500);
    rst = 1'b0;
    step();
    check("midrst_valid_t5", int'(sample_valid), 0);
    check("midrst_sample_out", int'(sample_out), MID);
    check("midrst_sample_ch", int'(sample_ch), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_frame_done", int'(frame_done), 0);
    rst = 1'b1;
    vcount = 0;
    for (int j = 0; j < 6; j++) begin
      if (sample_valid) vcount++;
      step();
    end
    check("midrst_no_valids", vcount, 0);

    // ---- randomized frames against the reference model ----
    do_reset();
    for (int f = 0; f < 60; f++) begin
      n_idle = $urandom_range(0, 3);
      for (int c = 0; c < n_idle; c++) begin
        if ($urandom_range(0, 1) == 1) begin
          wch = $urandom_range(0, CHANNELS - 1);
          waddr = $urandom_range(0, 3);
          wdata = $urandom_range(0, PMOD - 1);
          cfg_we = 1'b1; cfg_ch = CH_W'(wch); cfg_addr = 2'(waddr); cfg_data = PHASE_W'(wdata);
          model_write(wch, waddr, wdata);
        end
        if ($urandom_range(0, 5) == 0) begin
          phase_sync = 1'b1;
          m_pend = 1'b1;
        end
        step();
        clear_inputs();
      end
      we = ($urandom_range(0, 3) == 0);
      ps = ($urandom_range(0, 7) == 0);
      wch = $urandom_range(0, CHANNELS - 1);
      waddr = $urandom_range(0, 3);
      wdata = $urandom_range(0, PMOD - 1);
      cfg_we = we; cfg_ch = CH_W'(wch); cfg_addr = 2'(waddr); cfg_data = PHASE_W'(wdata);
      phase_sync = ps;
      model_frame(ps, we, wch, waddr, wdata);
      run_frame();
      for (int k = 0; k < CHANNELS; k++) begin
        if (exp_q.size() == 0) begin
          check("rand_queue_empty", 1, 0);
        end else begin
          check("rand_sample", int'(got_s[k]), int'(exp_q.pop_front()));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Time limit: the whole run needs only a few thousand cycles.
  initial begin
    #2000000;
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dds_multichannel_core.md
Name: dds_multichannel_core

Overview:
Parametrised, time-multiplexed DDS core producing CHANNELS independent waveforms from one shared pipeline. It runs in the generator clock domain and replaces the single-channel accumulator, phase-to-amplitude and amplitude-control chain. It adds per-channel phase offset, shadowed configuration, synchronous phase reset and overrun detection. Each accepted sample_tick emits one sample per channel, in channel order, to the DAC/SPI stage.

Parameters:
CHANNELS, 2, number of channels (1..16); CH_W = max(1, clog2(CHANNELS)) is derived locally.
PHASE_W, 14, phase accumulator width; must satisfy PHASE_W >= OUT_W+1, PHASE_W >= TUNE_W and PHASE_W >= AMP_W.
TUNE_W, 13, tuning word (M) width.
AMP_W, 11, amplitude scale width.
OUT_W, 12, output sample width (unsigned, offset-binary).

Ports:
clk  in  1  core clock.
rst  in  1  synchronous reset, active-low; sampled on the rising edge of clk.
sample_tick  in  1  one-cycle frame request.
phase_sync  in  1  request to zero all accumulators at the next frame.
cfg_we  in  1  configuration write strobe.
cfg_ch  in  CH_W  target channel; writes with cfg_ch >= CHANNELS are ignored.
cfg_addr  in  2  0 = tune, 1 = phase offset, 2 = amplitude, 3 = shape.
cfg_data  in  PHASE_W  write data, LSB-aligned; excess bits are ignored.
overrun_clr  in  1  clears overrun.
sample_out  out  OUT_W  scaled sample.
sample_ch  out  CH_W  channel index of sample_out.
sample_valid  out  1  sample_out/sample_ch are valid this cycle.
frame_done  out  1  pulses together with the last channel's sample_valid.
busy  out  1  frame in progress.
overrun  out  1  sticky: a tick arrived while busy.

Behaviour:
- Reset (rst = 0):
  - all shadow and active registers: tune 0, offset 0, amp 0, shape 3 (off).
  - accumulators 0, sync pending 0, FSM to IDLE, pipeline cleared.
  - outputs: sample_out = 2^(OUT_W-1), sample_ch 0, sample_valid/frame_done/busy/overrun 0.
  - reset mid-frame aborts the frame; no further valids are emitted.
- Config:
  - a write updates the shadow register on the next edge.
  - shadow is copied to active on an accepted tick; the copy uses pre-write shadow, so a write in the tick cycle takes effect next frame.
- FSM IDLE -> RUN on sample_tick:
  - tick accepted in cycle T; busy = 1 from T+1.
  - channel k is issued in cycle T+1+k; RUN -> DRAIN after the last issue.
  - DRAIN -> IDLE when the last sample is output; busy = 0 from cycle T+CHANNELS+4.
- sample_tick while busy: ignored, overrun <= 1. overrun_clr and a tick-while-busy in the same cycle leave overrun = 1.
- phase_sync: latched as pending at any time; consumed by the next accepted tick.
- Issue (stage 1), per channel:
  - p = (acc + offset) mod 2^PHASE_W; acc <= (acc + tune) mod 2^PHASE_W (wraps silently).
  - with sync pending: p = offset, acc <= tune.
  - shape 3: acc is held (sync still zeroes it).
- Waveform (stage 2), raw is OUT_W bits:
  - 0 saw: raw = p[PHASE_W-1 -: OUT_W].
  - 1 triangle: raw = p[MSB] ? ~p[PHASE_W-2 -: OUT_W] : p[PHASE_W-2 -: OUT_W].
  - 2 square: raw = p[MSB] ? 0 : all-ones.
  - 3 off: raw = 2^(OUT_W-1).
- Scale (stage 3):
  - s = raw - 2^(OUT_W-1) (signed); sample_out = 2^(OUT_W-1) + floor(s*amp / 2^AMP_W), using an arithmetic shift.
  - result is always within range; no clamp is needed.
- Latency: channel k sample_valid at T+4+k with sample_ch = k. Valids are contiguous; frame_done coincides with k = CHANNELS-1.
- sample_out holds its last value when sample_valid = 0.

Test Plan:
1. Reset, then tick with no config -> ch0 and ch1 both output 2048 at T+4 and T+5; frame_done at T+5; busy low at T+6.
2. ch0: tune 1024, saw, amp 2047; phase_sync, then 3 ticks -> ch0 samples 1, 256, 512.
3. ch1: square, amp 1024, tune 4096; sync, then ticks -> 3071, 3071, 1024, 1024, 3071 repeating; ch0 still off (2048).
4. ch0: tune 8191, offset 0x3F00, saw, amp 2047, sync -> phases 0x3F00, 0x1EFF, 0x3EFE, 0x1EFD; checks wrap mod 16384.
5. Tick at T and again at T+2 -> second tick ignored, overrun = 1 and stays set until overrun_clr; exactly 2 valids emitted.
6. Write amp in the tick cycle -> old amp used this frame, new amp next frame; rst low at T+4 -> no valid at T+5, outputs at reset values.
